// File: rtl/store_merge.sv
// Sub-word store unit for a word-only data memory: byte/half stores become a
// read-modify-write, word stores go straight out, misaligned requests are rejected.
module store_merge (
   input  logic        clk,
   input  logic        reset,
   input  logic        st_valid,
   output logic        st_ready,
   input  logic [31:0] st_addr,
   input  logic [31:0] st_data,
   input  logic [1:0]  st_type,
   output logic [31:0] mem_addr,
   output logic        mem_rd_en,
   input  logic [31:0] mem_rdata,
   output logic        mem_wr_en,
   output logic [31:0] mem_wdata,
   output logic        done,
   output logic        misalign
);

   typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, ERR} state_t;

   state_t      state_q;
   logic [31:0] addr_q;
   logic [31:0] data_q;
   logic [31:0] word_q;
   logic [1:0]  type_q;

   logic        st_is_word;
   logic        st_misaligned;
   logic        q_is_word;
   logic [3:0]  lane_sel;
   logic [31:0] merged_word;

   assign st_is_word    = (st_type == 2'd0) || (st_type == 2'd3);
   assign st_misaligned = ((st_type == 2'd2) && st_addr[0]) ||
                          (st_is_word && (st_addr[1:0] != 2'b00));
   assign q_is_word     = (type_q == 2'd0) || (type_q == 2'd3);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         word_q  <= '0;
         type_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (st_valid) begin
                  addr_q <= st_addr;
                  data_q <= st_data;
                  type_q <= st_type;
                  if (st_misaligned)   state_q <= ERR;
                  else if (st_is_word) state_q <= WRITE;
                  else                 state_q <= READ;
               end
            end
            READ:  state_q <= MERGE;
            MERGE: begin
               word_q  <= mem_rdata;
               state_q <= WRITE;
            end
            WRITE:   state_q <= IDLE;
            ERR:     state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Each byte lane takes store data when selected; half stores feed odd lanes
   // from data_q[15:8], byte stores always feed from data_q[7:0].
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = gi[1:0];
      localparam int         SRC  = (gi % 2) * 8;
      assign lane_sel[gi] = (type_q == 2'd1) ? (addr_q[1:0] == LANE)
                                             : (addr_q[1] == LANE[1]);
      assign merged_word[8*gi +: 8] = !lane_sel[gi]     ? word_q[8*gi +: 8] :
                                      (type_q == 2'd1)  ? data_q[7:0]       :
                                                          data_q[SRC +: 8];
   end

   assign st_ready  = (state_q == IDLE);
   assign mem_rd_en = (state_q == READ);
   assign mem_wr_en = (state_q == WRITE);
   assign done      = (state_q == WRITE);
   assign misalign  = (state_q == ERR);
   assign mem_addr  = {addr_q[31:2], 2'b00};
   assign mem_wdata = (state_q != WRITE) ? 32'h0 :
                      q_is_word          ? data_q : merged_word;

endmodule

// File: tb/tb_store_merge.sv
// Self-checking bench for store_merge: a byte-array memory model predicts every
// merged word and the cycle-by-cycle handshake of each store.
module tb_store_merge;

   logic        clk = 1'b0;
   logic        reset;
   logic        st_valid;
   logic        st_ready;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic [1:0]  st_type;
   logic [31:0] mem_addr;
   logic        mem_rd_en;
   logic [31:0] mem_rdata;
   logic        mem_wr_en;
   logic [31:0] mem_wdata;
   logic        done;
   logic        misalign;

   int vectors     = 0;
   int miscompares = 0;
   int wr_seen     = 0;
   int wr_expected = 0;

   logic [31:0] ram     [64];
   logic [31:0] ref_mem [64];

   store_merge dut (
      .clk(clk), .reset(reset),
      .st_valid(st_valid), .st_ready(st_ready),
      .st_addr(st_addr), .st_data(st_data), .st_type(st_type),
      .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
      .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
      .done(done), .misalign(misalign)
   );

   always #5 clk = ~clk;

   // Synchronous word RAM: read data appears the cycle after mem_rd_en.
   always @(posedge clk) begin
      if (mem_rd_en) mem_rdata <= ram[mem_addr[7:2]];
      if (mem_wr_en) ram[mem_addr[7:2]] <= mem_wdata;
   end

   always @(negedge clk) if (mem_wr_en === 1'b1) wr_seen++;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Issue one store and check every cycle until the unit is ready again.
   task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] t, input string tag);
      logic [7:0]  b [4];
      logic [31:0] exp_word;
      logic [31:0] exp_addr;
      logic        mis;
      int          size;
      int          n;
      logic [4:0]  ef [4];
      logic [4:0]  got;
      mis      = ((t == 2'd2) && a[0]) || (((t == 2'd0) || (t == 2'd3)) && (a[1:0] != 2'b00));
      size     = (t == 2'd1) ? 1 : (t == 2'd2) ? 2 : 4;
      exp_addr = {a[31:2], 2'b00};
      for (int i = 0; i < 4; i++) b[i] = ref_mem[a[7:2]][8*i +: 8];
      if (!mis) for (int i = 0; i < size; i++) b[int'(a[1:0]) + i] = d[8*i +: 8];
      exp_word = {b[3], b[2], b[1], b[0]};
      // flags = {st_ready, mem_rd_en, mem_wr_en, done, misalign}
      if (mis) begin
         n = 2; ef = '{5'b00001, 5'b10000, 5'b00000, 5'b00000};
      end else if (size == 4) begin
         n = 2; ef = '{5'b00110, 5'b10000, 5'b00000, 5'b00000};
      end else begin
         n = 4; ef = '{5'b01000, 5'b00000, 5'b00110, 5'b10000};
      end
      @(negedge clk);
      st_addr = a; st_data = d; st_type = t; st_valid = 1'b1;
      vectors++;
      if (st_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL %s ready_before_accept: got %b expected 1", tag, st_ready);
      end
      @(posedge clk);
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         st_valid = 1'b0;
         got = {st_ready, mem_rd_en, mem_wr_en, done, misalign};
         vectors++;
         if (got !== ef[c]) begin
            miscompares++;
            $display("FAIL %s flags_cycle%0d: got %b expected %b", tag, c + 1, got, ef[c]);
         end
         if (c < n - 1) begin
            vectors++;
            if (mem_addr !== exp_addr) begin
               miscompares++;
               $display("FAIL %s mem_addr_cycle%0d: got %h expected %h", tag, c + 1, mem_addr, exp_addr);
            end
         end
         if (ef[c][2]) begin
            vectors++;
            if (mem_wdata !== exp_word) begin
               miscompares++;
               $display("FAIL %s mem_wdata: got %h expected %h", tag, mem_wdata, exp_word);
            end
         end
      end
      if (!mis) begin
         ref_mem[a[7:2]] = exp_word;
         wr_expected++;
      end
      $display("store %s type=%0d addr=%h data=%h misaligned=%0d expect_word=%h",
               tag, t, a, d, mis, exp_word);
   endtask

   task automatic test_reset();
      logic [6:0] got;
      reset = 1'b1; st_valid = 1'b1; st_addr = 32'h40; st_data = 32'h12345678; st_type = 2'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      got = {st_ready, mem_rd_en, mem_wr_en, done, misalign, |mem_addr, |mem_wdata};
      vectors++;
      if (got !== 7'b1000000) begin
         miscompares++;
         $display("FAIL reset_outputs: got %b expected 1000000", got);
      end
      reset = 1'b0; st_valid = 1'b0;
      @(negedge clk);
      got = {st_ready, mem_rd_en, mem_wr_en, done, misalign, |mem_addr, |mem_wdata};
      vectors++;
      if (got !== 7'b1000000) begin
         miscompares++;
         $display("FAIL after_reset_idle: got %b expected 1000000", got);
      end
      $display("reset check done");
   endtask

   task automatic test_directed();
      ram[4] = 32'h11223344; ref_mem[4] = 32'h11223344;
      do_store(32'h10, 32'hDEADBEEF, 2'd0, "sw_0x10");
      @(negedge clk);
      vectors++;
      if (ram[4] !== 32'hDEADBEEF) begin
         miscompares++;
         $display("FAIL sw_ram_word: got %h expected deadbeef", ram[4]);
      end
      ram[4] = 32'h11223344; ref_mem[4] = 32'h11223344;
      do_store(32'h13, 32'h000000AB, 2'd1, "sb_0x13");
      @(negedge clk);
      vectors++;
      if (ram[4] !== 32'hAB223344) begin
         miscompares++;
         $display("FAIL sb_ram_word: got %h expected ab223344", ram[4]);
      end
      ram[8] = 32'h11223344; ref_mem[8] = 32'h11223344;
      do_store(32'h22, 32'h0000CAFE, 2'd2, "sh_0x22");
      @(negedge clk);
      vectors++;
      if (ram[8] !== 32'hCAFE3344) begin
         miscompares++;
         $display("FAIL sh_hi_ram_word: got %h expected cafe3344", ram[8]);
      end
      ram[8] = 32'h11223344; ref_mem[8] = 32'h11223344;
      do_store(32'h20, 32'h0000CAFE, 2'd2, "sh_0x20");
      @(negedge clk);
      vectors++;
      if (ram[8] !== 32'h1122CAFE) begin
         miscompares++;
         $display("FAIL sh_lo_ram_word: got %h expected 1122cafe", ram[8]);
      end
   endtask

   task automatic test_misalign();
      do_store(32'h21, 32'h0000BEEF, 2'd2, "sh_0x21_mis");
      do_store(32'h12, 32'hCAFEF00D, 2'd0, "sw_0x12_mis");
      do_store(32'h33, 32'h01020304, 2'd3, "sw3_0x33_mis");
   endtask

   task automatic test_reset_abort();
      logic [4:0] got;
      @(negedge clk);
      st_addr = 32'h13; st_data = 32'h000000EE; st_type = 2'd1; st_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      st_valid = 1'b0;
      vectors++;
      if (mem_rd_en !== 1'b1) begin
         miscompares++;
         $display("FAIL abort_read_issued: got %b expected 1", mem_rd_en);
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      got = {st_ready, mem_rd_en, mem_wr_en, done, misalign};
      vectors++;
      if (got !== 5'b10000 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
         miscompares++;
         $display("FAIL abort_after_reset: flags %b addr %h wdata %h expected 10000 0 0",
                  got, mem_addr, mem_wdata);
      end
      reset = 1'b0;
      @(negedge clk);
      got = {st_ready, mem_rd_en, mem_wr_en, done, misalign};
      vectors++;
      if (got !== 5'b10000) begin
         miscompares++;
         $display("FAIL abort_idle_after_release: got %b expected 10000", got);
      end
      $display("store sb_0x13 aborted by reset in MERGE");
      do_store(32'h10, $urandom, 2'd0, "sw_0x10_after_abort");
   endtask

   task automatic test_back_to_back();
      logic [31:0] dw;
      logic [31:0] db;
      logic [31:0] e1;
      logic [1:0]  got;
      logic [1:0]  want;
      dw = $urandom; db = $urandom;
      e1 = ref_mem[1];
      e1[15:8] = db[7:0];
      @(negedge clk);
      st_addr = 32'h0; st_data = dw; st_type = 2'd0; st_valid = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         got  = {st_ready, done};
         want = {(c == 2) || (c == 6), (c == 1) || (c == 5)};
         vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL b2b_cycle%0d ready_done: got %b expected %b", c, got, want);
         end
         if (c == 1 || c == 5) begin
            vectors++;
            if (mem_wdata !== ((c == 1) ? dw : e1)) begin
               miscompares++;
               $display("FAIL b2b_wdata_cycle%0d: got %h expected %h", c, mem_wdata, (c == 1) ? dw : e1);
            end
         end
         if (c == 1) begin
            st_addr = 32'h5; st_data = db; st_type = 2'd1;
         end
         if (c == 3) st_valid = 1'b0;
      end
      ref_mem[0] = dw;
      ref_mem[1] = e1;
      wr_expected += 2;
      $display("store back_to_back sw 0x0=%h then sb 0x5=%h", dw, db[7:0]);
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++)
         do_store($urandom_range(0, 255), $urandom, 2'($urandom_range(0, 3)), "random");
   endtask

   task automatic test_final_memory();
      @(negedge clk);
      for (int w = 0; w < 64; w++) begin
         vectors++;
         if (ram[w] !== ref_mem[w]) begin
            miscompares++;
            $display("FAIL final_ram_word%0d: got %h expected %h", w, ram[w], ref_mem[w]);
         end
      end
      vectors++;
      if (wr_seen !== wr_expected) begin
         miscompares++;
         $display("FAIL write_pulse_count: got %0d expected %0d", wr_seen, wr_expected);
      end
   endtask

   initial begin
      for (int w = 0; w < 64; w++) begin
         ram[w]     = $urandom;
         ref_mem[w] = ram[w];
      end
      mem_rdata = 32'h0;
      test_reset();
      test_directed();
      test_misalign();
      test_reset_abort();
      test_back_to_back();
      test_random();
      test_final_memory();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
